pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives per-stage enable/flush for the
//  pc, if_id, id_ex, ex_mem and mem_wb stage registers. Resolves load-use hazards, EX-stage
//  redirects, instruction-fetch waits and multi-cycle data-memory waits (with timeout).
//  Keeps a stall-cycle performance counter.
// PARAMETERS
//  REG_AW      5     register-index width
//  DMEM_TMO    64    max cycles in DMEM_WAIT before bus error (>=2)
//  CNT_W       32    width of stall_cycles counter (saturating)
// PORTS
//  clk           in   1       clock
//  reset         in   1       asynchronous, active-high
//  id_rs1/id_rs2 in   REG_AW  source regs of instr in ID
//  id_use_rs1/2  in   1       ID instr actually reads rs1/rs2
//  ex_rd         in   REG_AW  dest reg of instr in EX
//  ex_is_load    in   1       EX instr is a load
//  ex_redirect   in   1       EX resolved taken branch/jump (pc must take target)
//  imem_ack      in   1       fetch data valid this cycle
//  mem_req       in   1       MEM-stage instr accesses dmem
//  dmem_ack      in   1       dmem access completes this cycle
//  pc_en, if_id_en, id_ex_en, ex_mem_en  out 1  stage register load enables
//  if_id_flush, id_ex_flush, mem_wb_flush out 1 load a bubble instead of data
//  bus_err       out  1       sticky: dmem timeout occurred
//  stall_cycles  out  CNT_W   cycles in which pc_en==0, saturating
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, stall_cycles=0, bus_err=0; while reset high all *_en=0, all flush=0.
//  Stage outputs are combinational from state + inputs; only FSM/counters are registered.
//  FSM states: RUN, DMEM_WAIT, ERR.
//   RUN -> DMEM_WAIT when mem_req && !dmem_ack (wait_cnt<=1). Zero-wait access (ack same cycle) stays RUN.
//   DMEM_WAIT: wait_cnt++ per cycle; dmem_ack -> RUN (wait_cnt<=0); wait_cnt==DMEM_TMO-1 without ack -> ERR.
//   ERR: bus_err=1, all en=0, no flush; held until reset.
//  Priority per cycle (highest first):
//   1 dmem stall (mem_req && !dmem_ack, any non-ERR state): pc/if_id/id_ex/ex_mem en=0, mem_wb_flush=1,
//     other flushes 0. redirect/load-use ignored (EX frozen, so they re-present on release).
//   2 ex_redirect: all en=1, if_id_flush=1, id_ex_flush=1 (kills 2 wrong-path instrs; load-use and
//     imem wait of wrong-path ID instr ignored).
//   3 load-use: ex_is_load && ex_rd!=0 && ((id_use_rs1&&id_rs1==ex_rd)||(id_use_rs2&&id_rs2==ex_rd)):
//     pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Exactly one bubble per hazard.
//   4 !imem_ack: pc_en=0, if_id_flush=1, if_id_en=1, downstream en=1.
//   5 else all en=1, all flush=0.
//  Cycle with dmem_ack=1 in DMEM_WAIT is a normal (priority 2..5) cycle.
//  stall_cycles += 1 when !reset && pc_en==0 (includes ERR), saturates at all-ones.
//  bus_err sets on entry to ERR; cleared only by reset. Reset mid-wait: returns to RUN immediately.
//  Flush on a stage implies its en is ignored by the stage register (flush wins).
// STRUCTURE
//  Package pipe_ctrl_pkg: typedef enum logic[1:0] {RUN,DMEM_WAIT,ERR} pctl_state_e;
//   typedef struct packed {logic en; logic flush;} stage_ctl_t; shared with stage-register modules.
//  Sub-module load_use_detect (combinational, REG_AW param) -> hazard bit; rest in this module.
// TESTING
//  1 ex_is_load=1,ex_rd=5,id_rs1=5,id_use_rs1=1 -> 1 cycle pc_en=0,if_id_en=0,id_ex_flush=1; next cycle normal.
//  2 same but ex_rd=0 -> no stall; id_use_rs1=0 -> no stall.
//  3 ex_redirect=1 with load-use also true -> if_id_flush=id_ex_flush=1, pc_en=1, no stall.
//  4 mem_req=1, dmem_ack after 3 cycles -> 3 frozen cycles, mem_wb_flush=1 each, stall_cycles +3, back to RUN.
//  5 mem_req=1, no ack, DMEM_TMO=4 -> ERR after 4 wait cycles, bus_err=1 sticky; reset clears to RUN/0.
//  6 imem_ack=0 for 2 cycles -> pc_en=0, if_id_flush=1 each; reset asserted mid-DMEM_WAIT -> RUN, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer and the stage-register modules.
//   pctl_state_e : sequencer FSM state encoding
//   stage_ctl_t  : per-stage load-enable / bubble-insert control pair
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DMEM_WAIT = 2'd1,
      ERR       = 2'd2
   } pctl_state_e;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
//   master : pipeline side, drives hazard sources, receives stage controls
//   slave  : sequencer side, observes hazard sources, drives stage controls
//   Hazard sources : id_rs1/2, id_use_rs1/2, ex_rd, ex_is_load, ex_redirect,
//                    imem_ack, mem_req, dmem_ack
//   Stage controls : pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
//                    id_ex_flush, mem_wb_flush, bus_err, stall_cycles
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
);
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_is_load;
   logic              ex_redirect;
   logic              imem_ack;
   logic              mem_req;
   logic              dmem_ack;

   logic              pc_en;
   logic              if_id_en;
   logic              id_ex_en;
   logic              ex_mem_en;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              mem_wb_flush;
   logic              bus_err;
   logic [CNT_W-1:0]  stall_cycles;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
             ex_redirect, imem_ack, mem_req, dmem_ack,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
             mem_wb_flush, bus_err, stall_cycles
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
             ex_redirect, imem_ack, mem_req, dmem_ack,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
             mem_wb_flush, bus_err, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID source operands and their use flags
//   ex_rd, ex_is_load                    : EX destination and load flag
//   hazard                               : one bubble is required
module load_use_detect #(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   output logic              hazard
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   always_comb begin
      rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
      rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
      hazard  = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk, reset : clock, asynchronous active-high reset
//   hz (slave) : hazard sources in; pc/if_id/id_ex/ex_mem enables, if_id/id_ex/mem_wb
//                flushes, sticky bus_err and saturating stall_cycles out
// Stage controls are combinational from state + inputs; only the FSM, the
// dmem wait counter, bus_err and the stall counter are registered.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned DMEM_TMO = 64,
   parameter int unsigned CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   pipe_hazard_ctrl_if.slave  hz
);

   localparam int unsigned        WAIT_W    = (DMEM_TMO > 2) ? $clog2(DMEM_TMO) : 1;
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(DMEM_TMO - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   pctl_state_e       state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              bus_err_q;
   logic [CNT_W-1:0]  stall_q;

   logic              load_use_c;
   logic              dmem_stall_c;
   logic              pc_en_c;
   stage_ctl_t        if_id_c;
   stage_ctl_t        id_ex_c;
   logic              ex_mem_en_c;
   logic              mem_wb_flush_c;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use (
      .id_rs1     (hz.id_rs1),
      .id_rs2     (hz.id_rs2),
      .id_use_rs1 (hz.id_use_rs1),
      .id_use_rs2 (hz.id_use_rs2),
      .ex_rd      (hz.ex_rd),
      .ex_is_load (hz.ex_is_load),
      .hazard     (load_use_c)
   );

   assign dmem_stall_c = hz.mem_req && !hz.dmem_ack;

   // Per-cycle stage control, highest priority first
   always_comb begin
      pc_en_c        = 1'b0;
      if_id_c        = '0;
      id_ex_c        = '0;
      ex_mem_en_c    = 1'b0;
      mem_wb_flush_c = 1'b0;
      if (reset || state == ERR) begin
         // everything frozen, nothing flushed
      end else if (dmem_stall_c) begin
         // MEM frozen: hold everything upstream, feed a bubble into WB;
         // redirect/load-use in EX/ID re-present after release
         mem_wb_flush_c = 1'b1;
      end else if (hz.ex_redirect) begin
         pc_en_c       = 1'b1;
         if_id_c       = '{en: 1'b1, flush: 1'b1};
         id_ex_c       = '{en: 1'b1, flush: 1'b1};
         ex_mem_en_c   = 1'b1;
      end else if (load_use_c) begin
         // hold PC and IF/ID, one bubble into EX while the load advances
         id_ex_c       = '{en: 1'b1, flush: 1'b1};
         ex_mem_en_c   = 1'b1;
      end else if (!hz.imem_ack) begin
         // no fetch data: hold PC, bubble into ID, drain downstream
         if_id_c       = '{en: 1'b1, flush: 1'b1};
         id_ex_c.en    = 1'b1;
         ex_mem_en_c   = 1'b1;
      end else begin
         pc_en_c       = 1'b1;
         if_id_c.en    = 1'b1;
         id_ex_c.en    = 1'b1;
         ex_mem_en_c   = 1'b1;
      end
   end

   // Sequencer FSM, dmem wait timer, sticky bus error and stall counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
         stall_q   <= '0;
      end else begin
         if (!pc_en_c && stall_q != CNT_MAX) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         case (state)
            RUN: begin
               if (dmem_stall_c) begin
                  state    <= DMEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            DMEM_WAIT: begin
               // an ack on the last allowed cycle still completes normally
               if (!dmem_stall_c) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state     <= ERR;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ERR: begin
               // held until reset
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   assign hz.pc_en        = pc_en_c;
   assign hz.if_id_en     = if_id_c.en;
   assign hz.if_id_flush  = if_id_c.flush;
   assign hz.id_ex_en     = id_ex_c.en;
   assign hz.id_ex_flush  = id_ex_c.flush;
   assign hz.ex_mem_en    = ex_mem_en_c;
   assign hz.mem_wb_flush = mem_wb_flush_c;
   assign hz.bus_err      = bus_err_q;
   assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (DMEM_TMO=4, 4-bit stall counter).
module tb_pipe_hazard_ctrl;

   localparam int unsigned REG_AW   = 5;
   localparam int unsigned DMEM_TMO = 4;
   localparam int unsigned CNT_W    = 4;

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush, bus_err}
   localparam logic [7:0] V_OFF  = 8'b0000_000_0;
   localparam logic [7:0] V_NORM = 8'b1111_000_0;
   localparam logic [7:0] V_LU   = 8'b0011_010_0;
   localparam logic [7:0] V_REDR = 8'b1111_110_0;
   localparam logic [7:0] V_IMEM = 8'b0111_100_0;
   localparam logic [7:0] V_DMEM = 8'b0000_001_0;
   localparam logic [7:0] V_ERR  = 8'b0000_000_1;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [7:0] o;

   pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .DMEM_TMO(DMEM_TMO), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   assign o = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en,
               hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush, hz.bus_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
      hz.ex_rd = '0; hz.ex_is_load = 1'b0; hz.ex_redirect = 1'b0;
      hz.imem_ack = 1'b1; hz.mem_req = 1'b0; hz.dmem_ack = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      set_idle();
      hz.ex_redirect = 1'b1;
      hz.mem_req = 1'b1;
      reset = 1'b1;
      #1;
      checks++; if (o !== V_OFF) begin errors++; $display("FAIL reset_outs got=%b exp=%b", o, V_OFF); end
      tick();
      checks++; if (hz.stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", hz.stall_cycles); end
      set_idle();
      reset = 1'b0;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL reset_release got=%b exp=%b", o, V_NORM); end
   endtask

   task automatic test_load_use();
      do_reset();
      hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_use_rs1 = 1'b1;
      #1;
      checks++; if (o !== V_LU) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", o, V_LU); end
      tick();
      hz.ex_is_load = 1'b0;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL lu_after got=%b exp=%b", o, V_NORM); end
      checks++; if (hz.stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_stall got=%0d exp=1", hz.stall_cycles); end
      // rs2 match; rs1 also equal but unused
      hz.ex_is_load = 1'b1; hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7; hz.id_use_rs1 = 1'b0;
      hz.id_rs2 = 5'd7; hz.id_use_rs2 = 1'b1;
      #1;
      checks++; if (o !== V_LU) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", o, V_LU); end
      tick();
      hz.ex_is_load = 1'b0;
      #1;
      checks++; if (hz.stall_cycles !== 4'd2) begin errors++; $display("FAIL lu_stall2 got=%0d exp=2", hz.stall_cycles); end
   endtask

   task automatic test_no_stall();
      do_reset();
      hz.ex_is_load = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_use_rs1 = 1'b1;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL ns_rd0 got=%b exp=%b", o, V_NORM); end
      hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5; hz.id_use_rs1 = 1'b0;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL ns_unused got=%b exp=%b", o, V_NORM); end
      hz.id_rs1 = 5'd4; hz.id_use_rs1 = 1'b1;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL ns_differ got=%b exp=%b", o, V_NORM); end
      hz.id_rs1 = 5'd5; hz.ex_is_load = 1'b0;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL ns_notload got=%b exp=%b", o, V_NORM); end
      tick();
      checks++; if (hz.stall_cycles !== 4'd0) begin errors++; $display("FAIL ns_stall got=%0d exp=0", hz.stall_cycles); end
   endtask

   task automatic test_redirect();
      do_reset();
      hz.ex_redirect = 1'b1; hz.imem_ack = 1'b0;
      hz.ex_is_load = 1'b1; hz.ex_rd = 5'd3; hz.id_rs2 = 5'd3; hz.id_use_rs2 = 1'b1;
      #1;
      checks++; if (o !== V_REDR) begin errors++; $display("FAIL redir_outs got=%b exp=%b", o, V_REDR); end
      tick();
      checks++; if (hz.stall_cycles !== 4'd0) begin errors++; $display("FAIL redir_stall got=%0d exp=0", hz.stall_cycles); end
   endtask

   task automatic test_imem_wait();
      do_reset();
      hz.imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (o !== V_IMEM) begin errors++; $display("FAIL imem_wait%0d got=%b exp=%b", i, o, V_IMEM); end
         tick();
      end
      hz.imem_ack = 1'b1;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL imem_release got=%b exp=%b", o, V_NORM); end
      checks++; if (hz.stall_cycles !== 4'd2) begin errors++; $display("FAIL imem_stall got=%0d exp=2", hz.stall_cycles); end
   endtask

   task automatic test_dmem_wait();
      do_reset();
      hz.mem_req = 1'b1; hz.dmem_ack = 1'b0; hz.ex_redirect = 1'b1;
      hz.ex_is_load = 1'b1; hz.ex_rd = 5'd9; hz.id_rs1 = 5'd9; hz.id_use_rs1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (o !== V_DMEM) begin errors++; $display("FAIL dmem_frozen%0d got=%b exp=%b", i, o, V_DMEM); end
         tick();
      end
      hz.dmem_ack = 1'b1;
      #1;
      // ack cycle is a normal cycle: the held redirect now takes effect
      checks++; if (o !== V_REDR) begin errors++; $display("FAIL dmem_ack_cycle got=%b exp=%b", o, V_REDR); end
      checks++; if (hz.stall_cycles !== 4'd3) begin errors++; $display("FAIL dmem_stall got=%0d exp=3", hz.stall_cycles); end
      tick();
      set_idle();
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL dmem_after got=%b exp=%b", o, V_NORM); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int w = 0; w < 2; w++) begin
         hz.mem_req = 1'b1; hz.dmem_ack = 1'b0;
         for (int i = 0; i < 3; i++) tick();
         hz.dmem_ack = 1'b1;
         #1;
         checks++; if (o !== V_NORM) begin errors++; $display("FAIL b2b_ack%0d got=%b exp=%b", w, o, V_NORM); end
         tick();
      end
      // zero-wait access stays in RUN with no stall
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL b2b_zero_wait got=%b exp=%b", o, V_NORM); end
      tick();
      checks++; if (hz.stall_cycles !== 4'd6) begin errors++; $display("FAIL b2b_stall got=%0d exp=6", hz.stall_cycles); end
      checks++; if (hz.bus_err !== 1'b0) begin errors++; $display("FAIL b2b_bus_err got=%b exp=0", hz.bus_err); end
   endtask

   task automatic test_timeout();
      do_reset();
      hz.mem_req = 1'b1; hz.dmem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (o !== V_DMEM) begin errors++; $display("FAIL tmo_wait%0d got=%b exp=%b", i, o, V_DMEM); end
         tick();
      end
      checks++; if (o !== V_ERR) begin errors++; $display("FAIL tmo_err got=%b exp=%b", o, V_ERR); end
      checks++; if (hz.stall_cycles !== 4'd4) begin errors++; $display("FAIL tmo_stall got=%0d exp=4", hz.stall_cycles); end
      set_idle();
      hz.dmem_ack = 1'b1;
      #1;
      checks++; if (o !== V_ERR) begin errors++; $display("FAIL tmo_sticky got=%b exp=%b", o, V_ERR); end
      for (int i = 0; i < 15; i++) tick();
      checks++; if (hz.stall_cycles !== 4'd15) begin errors++; $display("FAIL tmo_saturate got=%0d exp=15", hz.stall_cycles); end
      checks++; if (o !== V_ERR) begin errors++; $display("FAIL tmo_held got=%b exp=%b", o, V_ERR); end
      reset = 1'b1;
      #1;
      checks++; if (hz.bus_err !== 1'b0 || hz.stall_cycles !== 4'd0) begin
         errors++; $display("FAIL tmo_reset bus_err=%b stall=%0d exp 0/0", hz.bus_err, hz.stall_cycles);
      end
      tick();
      set_idle();
      reset = 1'b0;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL tmo_after_reset got=%b exp=%b", o, V_NORM); end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      hz.mem_req = 1'b1; hz.dmem_ack = 1'b0;
      tick();
      tick();
      checks++; if (hz.stall_cycles !== 4'd2) begin errors++; $display("FAIL mid_pre_stall got=%0d exp=2", hz.stall_cycles); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (o !== V_OFF || hz.stall_cycles !== 4'd0) begin
         errors++; $display("FAIL mid_reset outs=%b stall=%0d exp %b/0", o, hz.stall_cycles, V_OFF);
      end
      tick();
      reset = 1'b0;
      // a fresh full-length wait must complete without timing out
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (o !== V_DMEM) begin errors++; $display("FAIL mid_wait%0d got=%b exp=%b", i, o, V_DMEM); end
         tick();
      end
      hz.dmem_ack = 1'b1;
      #1;
      checks++; if (o !== V_NORM) begin errors++; $display("FAIL mid_ack got=%b exp=%b", o, V_NORM); end
      checks++; if (hz.stall_cycles !== 4'd3) begin errors++; $display("FAIL mid_stall got=%0d exp=3", hz.stall_cycles); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      set_idle();
      #3;
      test_reset();
      test_load_use();
      test_no_stall();
      test_redirect();
      test_imem_wait();
      test_dmem_wait();
      test_back_to_back();
      test_timeout();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
